// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
//   DEF_DATA_W / DEF_DEPTH / DEF_NREAD : default parameter values
//   NWRITE                             : number of write ports
//   clog2                              : ceiling log2 used to size addresses
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 32;
  localparam int unsigned DEF_NREAD  = 2;
  localparam int unsigned NWRITE     = 2;

  // Ceiling log2; clog2(1) = 0, clog2(32) = 5.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking an in-flight producer.
//   clk, rst   : clock, synchronous active-low reset
//   set_i      : mark set_addr_i busy (issue)
//   clr_i      : per write port, clear busy for that port's address
//   clr_addr_i : packed write addresses, port p at [p*AW +: AW]
//   busy_o     : registered busy vector
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW   = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_i,
  input  logic [AW-1:0]        set_addr_i,
  input  logic [NWRITE-1:0]    clr_i,
  input  logic [NWRITE*AW-1:0] clr_addr_i,
  output logic [DEPTH-1:0]     busy_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Clears first, then the set, so a new producer outranks a completing one.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < int'(NWRITE); p++) begin
      if (clr_i[p]) begin
        busy_d[clr_addr_i[p*AW +: AW]] = 1'b0;
      end
    end
    if (set_i) begin
      busy_d[set_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Parametrised register file: NREAD combinational read ports, two write
// ports (port 1 wins on collision), optional write-to-read bypass, optional
// hard-wired zero register and a busy scoreboard for hazard detection.
//   clk, rst  : clock, synchronous active-low reset
//   we        : write enable per write port
//   waddr     : write addresses, port p at [p*AW +: AW]
//   wdata     : write data, port p at [p*DATA_W +: DATA_W]
//   raddr     : read addresses, port r at [r*AW +: AW]
//   rdata     : read data, port r at [r*DATA_W +: DATA_W] (combinational)
//   issue     : mark issue_rd as having a pending producer
//   issue_rd  : destination register of the issuing instruction
//   rbusy     : busy bit per read port (combinational)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned NREAD    = DEF_NREAD,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*AW-1:0]     waddr,
  input  logic [NWRITE*DATA_W-1:0] wdata,
  input  logic [NREAD*AW-1:0]      raddr,
  output logic [NREAD*DATA_W-1:0]  rdata,
  input  logic                     issue,
  input  logic [AW-1:0]            issue_rd,
  output logic [NREAD-1:0]         rbusy
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wa    [NWRITE];
  logic [DATA_W-1:0] wd    [NWRITE];
  logic [NWRITE-1:0] we_eff;
  logic              issue_eff;
  logic [DEPTH-1:0]  busy;

  // Unpack write ports; writes to r0 are dropped when it is hard-wired.
  for (genvar p = 0; p < int'(NWRITE); p++) begin : g_wr
    assign wa[p]     = waddr[p*AW +: AW];
    assign wd[p]     = wdata[p*DATA_W +: DATA_W];
    assign we_eff[p] = we[p] && !(ZERO_REG && (wa[p] == '0));
  end

  assign issue_eff = issue && !(ZERO_REG && (issue_rd == '0));

  regfile_scoreboard #(
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_i      (issue_eff),
    .set_addr_i (issue_rd),
    .clr_i      (we_eff),
    .clr_addr_i (waddr),
    .busy_o     (busy)
  );

  // Storage; port 1 is applied last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int p = 0; p < int'(NWRITE); p++) begin
        if (we_eff[p]) begin
          mem_q[wa[p]] <= wd[p];
        end
      end
    end
  end

  // Read ports with bypass and same-cycle busy clear masking.
  for (genvar r = 0; r < int'(NREAD); r++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rd_c;
    logic              clr_hit_c;

    assign ra = raddr[r*AW +: AW];

    always_comb begin
      rd_c      = mem_q[ra];
      clr_hit_c = 1'b0;
      for (int p = 0; p < int'(NWRITE); p++) begin
        if (we_eff[p] && (wa[p] == ra)) begin
          clr_hit_c = 1'b1;
          if (BYPASS) begin
            rd_c = wd[p];
          end
        end
      end
      if ((ZERO_REG && (ra == '0)) || !rst) begin
        rd_c = '0;
      end
    end

    assign rdata[r*DATA_W +: DATA_W] = rd_c;
    // The issue side only affects the next-cycle busy state, keeping issue
    // off every combinational output path.
    assign rbusy[r] = rst && busy[ra] && !clr_hit_c;
  end

endmodule : regfile_mp
